bin_to_bcd: RTL and testbench
=============================

Name:
bin_to_bcd

Overview:
- Pipelined converter from an 11-bit two's-complement binary value to sign-magnitude packed BCD.
- Output is a sign bit plus four decimal digits.
- Sits on a streaming datapath: accepts one sample per clock when `bin_vld` is high, and delivers results in order with fixed latency.
- No backpressure.

Parameters:
- None. Input width is fixed at 11 bits; output is fixed at 1 sign bit + 4 BCD digits.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `bin` input 11: two's-complement input, range -1024..+1023.
- `bin_vld` input 1: `bin` is valid this cycle.
- `bcd` output 17: [16] sign (1 = negative), [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- `bcd_vld` output 1: `bcd` holds a new result this cycle.

Behaviour:
- Reset: while `rst`=1, asynchronously force `bcd`=17'h0, `bcd_vld`=0 and all internal pipeline valid flags to 0.
  - Asserting reset mid-stream discards in-flight samples; no `bcd_vld` pulse is emitted for them.
  - First valid output appears 2 cycles after the first post-reset `bin_vld`.
- Stage 1, on a rising edge with `bin_vld`=1:
  - Register sign = `bin`[10].
  - Register magnitude = `bin`[10] ? (~`bin`+1) : `bin`, as a 11-bit unsigned value, range 0..1024.
  - Register valid = `bin_vld` every cycle.
- Stage 2: combinational double-dabble (shift-add-3) on the 11-bit magnitude produces 4 BCD digits.
  - On a rising edge where the stage-1 valid flag is 1, register `{sign, digits}` into `bcd`.
  - `bcd_vld` = stage-1 valid flag, registered.
- Latency: `bcd_vld`/`bcd` assert exactly 2 rising edges after the edge sampling `bin_vld`=1.
- Throughput: one result per clock. Back-to-back valids give back-to-back `bcd_vld`; gaps of any length are preserved exactly.
- `bcd_vld` is high for exactly one cycle per accepted sample.
- `bcd` holds its last value while `bcd_vld`=0. Data registers update only on valid, to save toggling.
- Zero: `bin`=0 gives sign 0, digits 0000. Negative zero cannot occur.
- -1024 (11'h400): magnitude 1024, output sign 1, digits 1024 (17'h11024). This is legal, not saturated.
- Every output digit is always 0..9. The thousands digit is at most 1.
- `bin` is ignored when `bin_vld`=0.
- No X propagation from `bin` into `bcd` when `bin_vld`=0.

Optional Feature:
- Macro `BIN2BCD_PIPE3_EN`.
- When defined:
  - Insert a pipeline register after the first 6 double-dabble shift iterations, holding partial BCD, the remaining magnitude bits, sign and valid.
  - Latency becomes 3 cycles; throughput is still 1/clk.
  - The register is reset to 0/invalid like the other stages.
- When undefined: latency is 2 cycles, as specified above.
- Results are bit-identical in both builds; only the delay differs.

Test Plan:
- Reset then idle: hold `rst`=1 for 10 cycles, release, keep `bin_vld`=0 for 5 cycles. Required: `bcd`=17'h0 and `bcd_vld`=0 throughout.
- Directed values, back-to-back (each `bin` sent with `bin_vld`=1, required `bcd`):
  - 11'h000 → 17'h00000
  - 11'h3FF (1023) → 17'h01023
  - 11'h7FF (-1) → 17'h10001
  - 11'h401 (-1023) → 17'h11023
  - 11'h400 (-1024) → 17'h11024
  - 11'h064 (100) → 17'h00100
  - Required timing: each result appears 2 cycles later (3 with `BIN2BCD_PIPE3_EN`).
- Full sweep: `bin`=0..2047 on consecutive cycles with `bin_vld`=1. Required:
  - 2048 consecutive `bcd_vld` pulses.
  - Each output matches the reference model: sign + decimal magnitude of the signed input.
- Random gaps: insert 0-15 idle cycles between single-cycle `bin_vld` pulses, both mostly-dense and mostly-sparse mixes. Required:
  - `bcd_vld` pulse pattern equals the `bin_vld` pattern delayed by the latency.
  - `bcd` is stable between pulses.
- Reset mid-stream: assert `rst` one cycle after sending 11'h123. Required:
  - `bcd_vld` never pulses for that sample.
  - `bcd`=17'h0 immediately, asynchronously.
  - The next post-reset sample 11'h7FE gives 17'h10002 at the normal latency.

Source files
------------

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: pipelined 11-bit two's-complement to sign + 4-digit packed BCD.
// Stage 1 registers sign/magnitude; a double-dabble stage produces the digits.
// Optional macro BIN2BCD_PIPE3_EN splits the double-dabble after 6 shifts,
// adding one cycle of latency (2 -> 3) with identical results.
module bin_to_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] bin,
  input  logic        bin_vld,
  output logic [16:0] bcd,
  output logic        bcd_vld
);

  localparam int unsigned BIN_W  = 11;
  localparam int unsigned DIG_W  = 16;
  localparam int unsigned SR_W   = DIG_W + BIN_W;
  localparam int unsigned NDIG   = 4;
  localparam int unsigned STEPS1 = 6;
  localparam int unsigned STEPS2 = BIN_W - STEPS1;

  // One shift-add-3 iteration on {bcd digits, remaining binary bits}.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int unsigned d = 0; d < NDIG; d++) begin
      if (t[BIN_W + 4*d +: 4] >= 4'd5) begin
        t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  logic              s1_sign;
  logic [BIN_W-1:0]  s1_mag;
  logic              s1_vld;

  logic              fin_sign;
  logic [SR_W-1:0]   fin_sr;
  logic              fin_vld;

  // Stage 1: capture sign and magnitude on valid; valid flag tracks every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= bin_vld;
      if (bin_vld) begin
        s1_sign <= bin[BIN_W-1];
        s1_mag  <= bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;
      end
    end
  end

`ifdef BIN2BCD_PIPE3_EN
  logic [SR_W-1:0] sr_a;
  logic [SR_W-1:0] s2_sr;
  logic            s2_sign;
  logic            s2_vld;

  // First half of the double-dabble, fed from stage 1.
  always_comb begin
    sr_a = {DIG_W'(0), s1_mag};
    for (int unsigned i = 0; i < STEPS1; i++) begin
      sr_a = dd_step(sr_a);
    end
  end

  // Mid-conversion register: partial BCD, remaining bits, sign and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sr   <= '0;
      s2_sign <= 1'b0;
      s2_vld  <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sr   <= sr_a;
        s2_sign <= s1_sign;
      end
    end
  end

  // Second half of the double-dabble.
  always_comb begin
    fin_sr = s2_sr;
    for (int unsigned i = 0; i < STEPS2; i++) begin
      fin_sr = dd_step(fin_sr);
    end
    fin_sign = s2_sign;
    fin_vld  = s2_vld;
  end
`else
  // Full double-dabble in a single combinational stage.
  always_comb begin
    fin_sr = {DIG_W'(0), s1_mag};
    for (int unsigned i = 0; i < BIN_W; i++) begin
      fin_sr = dd_step(fin_sr);
    end
    fin_sign = s1_sign;
    fin_vld  = s1_vld;
  end
`endif

  // Output register: data only moves on valid so bcd holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd     <= '0;
      bcd_vld <= 1'b0;
    end else begin
      bcd_vld <= fin_vld;
      if (fin_vld) begin
        bcd <= {fin_sign, fin_sr[SR_W-1:BIN_W]};
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: driver pushes expected results with their
// due cycle, a negedge monitor pops and checks data, timing and hold behaviour.
module tb_bin_to_bcd;

`ifdef BIN2BCD_PIPE3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] bin = '0;
  logic        bin_vld = 1'b0;
  logic [16:0] bcd;
  logic        bcd_vld;

  typedef struct {
    logic [16:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [16:0] hold_exp = '0;
  int          cyc = 0;
  int          asserts = 0;
  int          fails = 0;

  bin_to_bcd dut (
    .clk     (clk),
    .rst     (rst),
    .bin     (bin),
    .bin_vld (bin_vld),
    .bcd     (bcd),
    .bcd_vld (bcd_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Reference: sign + decimal digits of the signed input value.
  function automatic logic [16:0] ref_bcd(input logic [10:0] v);
    int s;
    int m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    return {(s < 0), 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic send(input logic [10:0] v, input logic [16:0] e);
    exp_t x;
    @(posedge clk); #1;
    bin     = v;
    bin_vld = 1'b1;
    x.data  = e;
    x.cyc   = cyc + LAT;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bin_vld = 1'b0;
      bin     = 11'($urandom);
    end
  endtask

  // Monitor: pop on each bcd_vld; otherwise bcd must hold the last result.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check("missed_vld_due_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (bcd_vld) begin
      if (sb.size() == 0) begin
        check("unexpected_vld", {15'h0, bcd}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("bcd_data", {15'h0, bcd}, {15'h0, e.data});
        check("bcd_latency", 32'(cyc), 32'(e.cyc));
        hold_exp = e.data;
      end
    end else begin
      check("bcd_hold", {15'h0, bcd}, {15'h0, hold_exp});
    end
  end

  logic [10:0] dv [6] = '{11'h000, 11'h3FF, 11'h7FF, 11'h401, 11'h400, 11'h064};
  logic [16:0] de [6] = '{17'h00000, 17'h01023, 17'h10001, 17'h11023, 17'h11024, 17'h00100};

  initial begin
    logic [10:0] v;
    int gap;
    // Reset then idle.
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);

    // Directed vectors, back-to-back, hand-computed results.
    for (int i = 0; i < 6; i++) send(dv[i], de[i]);
    idle(LAT + 3);

    // Full sweep over every input code.
    for (int i = 0; i < 2048; i++) send(11'(i), ref_bcd(11'(i)));
    idle(LAT + 3);

    // Random gaps: mostly dense, then mostly sparse.
    for (int i = 0; i < 60; i++) begin
      v = 11'($urandom);
      send(v, ref_bcd(v));
      gap = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 15);
      idle(gap);
    end
    for (int i = 0; i < 40; i++) begin
      v = 11'($urandom);
      send(v, ref_bcd(v));
      gap = ($urandom_range(0, 9) < 8) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      idle(gap);
    end
    idle(LAT + 3);

    // Reset mid-stream: in-flight 11'h123 must be dropped.
    send(11'h123, 17'h00291);
    @(posedge clk); #1;
    bin_vld  = 1'b0;
    rst      = 1'b1;
    sb.delete();
    hold_exp = '0;
    #1;
    check("async_rst_bcd", {15'h0, bcd}, 32'h0);
    check("async_rst_vld", {31'h0, bcd_vld}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send(11'h7FE, 17'h10002);
    idle(LAT + 5);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
